// File: rtl/adc_spi_ctrl.sv
// adc_spi_ctrl: frame controller for a 12-bit serial ADC.
// Drives chip-select and an idle-high serial clock. Strobes the downstream
// shift_in deserializer once per captured bit, then latches its word into
// a holding register with a one-cycle valid pulse.
module adc_spi_ctrl #(
    parameter int CLK_DIV      = 4,
    parameter int FRAME_BITS   = 16,
    parameter int LEAD_BITS    = 4,
    parameter int QUIET_CYCLES = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic        busy,
    output logic        adc_cs_n,
    output logic        adc_sclk,
    output logic        shift_ena,
    output logic        shift_clr_n,
    input  logic [11:0] shift_data,
    output logic [11:0] sample,
    output logic        sample_valid
);

    // One counter serves both the sclk half-period timing and the quiet gap.
    localparam int CNT_MAX = (CLK_DIV > QUIET_CYCLES) ? CLK_DIV : QUIET_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int BIT_W   = $clog2(FRAME_BITS + 1);

    localparam logic [CNT_W-1:0] DIV_LAST   = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] DIV_PRE    = CNT_W'(CLK_DIV - 2);
    localparam logic [CNT_W-1:0] QUIET_LAST = CNT_W'(QUIET_CYCLES - 1);
    localparam logic [BIT_W-1:0] BIT_LAST   = BIT_W'(FRAME_BITS - 1);
    localparam logic [BIT_W-1:0] LEAD       = BIT_W'(LEAD_BITS);

    if (FRAME_BITS - LEAD_BITS != 12) begin : g_bad_frame
        $error("adc_spi_ctrl: FRAME_BITS - LEAD_BITS must equal 12");
    end

    typedef enum logic [2:0] {
        IDLE,
        ASSERT,
        SHIFT,
        CAPTURE,
        QUIET
    } state_t;

    state_t           state, state_nx;
    logic [CNT_W-1:0] cnt, cnt_nx;
    logic [BIT_W-1:0] bitcnt, bitcnt_nx;
    logic             cs_n_nx, sclk_nx, ena_nx, clr_n_nx, busy_nx, valid_nx;
    logic             load_sample;

    // State, counters and every output are registered; rst aborts any frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            cnt          <= '0;
            bitcnt       <= '0;
            adc_cs_n     <= 1'b1;
            adc_sclk     <= 1'b1;
            shift_ena    <= 1'b0;
            shift_clr_n  <= 1'b0;
            busy         <= 1'b0;
            sample_valid <= 1'b0;
            sample       <= '0;
        end else begin
            state        <= state_nx;
            cnt          <= cnt_nx;
            bitcnt       <= bitcnt_nx;
            adc_cs_n     <= cs_n_nx;
            adc_sclk     <= sclk_nx;
            shift_ena    <= ena_nx;
            shift_clr_n  <= clr_n_nx;
            busy         <= busy_nx;
            sample_valid <= valid_nx;
            if (load_sample) begin
                sample <= shift_data;
            end
        end
    end

    // Next-state and next-output decode; outputs hold unless a state changes them.
    always_comb begin
        state_nx    = state;
        cnt_nx      = cnt;
        bitcnt_nx   = bitcnt;
        cs_n_nx     = adc_cs_n;
        sclk_nx     = adc_sclk;
        ena_nx      = 1'b0;
        clr_n_nx    = shift_clr_n;
        busy_nx     = busy;
        valid_nx    = 1'b0;
        load_sample = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nx = ASSERT;
                    cs_n_nx  = 1'b0;
                    busy_nx  = 1'b1;
                    cnt_nx   = '0;
                end
            end
            ASSERT: begin
                if (cnt == DIV_LAST) begin
                    state_nx  = SHIFT;
                    cnt_nx    = '0;
                    bitcnt_nx = '0;
                    sclk_nx   = 1'b0;
                    clr_n_nx  = 1'b1;
                end else begin
                    cnt_nx = cnt + 1'b1;
                end
            end
            SHIFT: begin
                if (cnt == DIV_LAST) begin
                    cnt_nx = '0;
                    if (!adc_sclk) begin
                        sclk_nx = 1'b1;
                    end else if (bitcnt == BIT_LAST) begin
                        state_nx = CAPTURE;
                    end else begin
                        sclk_nx   = 1'b0;
                        bitcnt_nx = bitcnt + 1'b1;
                    end
                end else begin
                    cnt_nx = cnt + 1'b1;
                    // Strobe lands in the last clk of the high phase.
                    if (adc_sclk && (cnt == DIV_PRE) && (bitcnt >= LEAD)) begin
                        ena_nx = 1'b1;
                    end
                end
            end
            CAPTURE: begin
                state_nx    = QUIET;
                load_sample = 1'b1;
                valid_nx    = 1'b1;
                cs_n_nx     = 1'b1;
                clr_n_nx    = 1'b0;
                cnt_nx      = '0;
            end
            QUIET: begin
                if (cnt == QUIET_LAST) begin
                    state_nx = IDLE;
                    busy_nx  = 1'b0;
                end else begin
                    cnt_nx = cnt + 1'b1;
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_adc_spi_ctrl.sv
// Testbench for adc_spi_ctrl: default-parameter and small-parameter instances,
// each with a behavioural ADC and shift_in deserializer model.
`timescale 1ns/1ps
module tb_adc_spi_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst1, start1, busy1, cs1, sclk1, ena1, clr1, valid1;
    logic [11:0] sd1, samp1;
    logic        rst2, start2, busy2, cs2, sclk2, ena2, clr2, valid2;
    logic [11:0] sd2, samp2;

    adc_spi_ctrl dut1 (
        .clk(clk), .rst(rst1), .start(start1), .busy(busy1),
        .adc_cs_n(cs1), .adc_sclk(sclk1), .shift_ena(ena1), .shift_clr_n(clr1),
        .shift_data(sd1), .sample(samp1), .sample_valid(valid1)
    );

    adc_spi_ctrl #(.CLK_DIV(2), .FRAME_BITS(12), .LEAD_BITS(0), .QUIET_CYCLES(1)) dut2 (
        .clk(clk), .rst(rst2), .start(start2), .busy(busy2),
        .adc_cs_n(cs2), .adc_sclk(sclk2), .shift_ena(ena2), .shift_clr_n(clr2),
        .shift_data(sd2), .sample(samp2), .sample_valid(valid2)
    );

    // ADC models: load the frame on cs_n falling, present next bit on sclk falling.
    logic [11:0] word1 = 12'h000, word2 = 12'h000;
    logic [15:0] f1 = '0;
    logic [11:0] f2 = '0;
    logic        miso1 = 1'b0, miso2 = 1'b0;

    always @(negedge cs1 or negedge sclk1) begin
        if (sclk1) f1 = {4'b0000, word1};
        else if (!cs1) begin
            miso1 = f1[15];
            f1    = f1 << 1;
        end
    end

    always @(negedge cs2 or negedge sclk2) begin
        if (sclk2) f2 = word2;
        else if (!cs2) begin
            miso2 = f2[11];
            f2    = f2 << 1;
        end
    end

    // shift_in models: clear while clr_n low, shift MSB-first on ena.
    always @(posedge clk) begin
        if (!clr1) sd1 <= '0;
        else if (ena1) sd1 <= {sd1[10:0], miso1};
        if (!clr2) sd2 <= '0;
        else if (ena2) sd2 <= {sd2[10:0], miso2};
    end

    int ncmp = 0;
    int nbad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        ncmp++;
        if (act !== exp) begin
            nbad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Launch one frame on the selected instance and measure it from E0.
    task automatic run_frame(input bit sel, input logic [11:0] w,
                             output int lat, output logic [11:0] s, output int nena,
                             output int nrise, output int ncs, output int bend, output int nval);
        logic cs, sc, en, bz, vl, psc;
        logic [11:0] sp;
        lat = -1; bend = -1; s = '0; nena = 0; nrise = 0; ncs = 0; nval = 0;
        if (sel) begin word2 = w; start2 = 1'b1; end
        else     begin word1 = w; start1 = 1'b1; end
        @(posedge clk); #1;
        start1 = 1'b0; start2 = 1'b0;
        psc = 1'b1;
        for (int n = 0; n < 150; n++) begin
            cs = sel ? cs2 : cs1;     sc = sel ? sclk2 : sclk1;
            en = sel ? ena2 : ena1;   bz = sel ? busy2 : busy1;
            vl = sel ? valid2 : valid1; sp = sel ? samp2 : samp1;
            if (!cs) ncs++;
            if (en) nena++;
            if (sc && !psc) nrise++;
            psc = sc;
            if (vl) begin
                nval++;
                if (lat < 0) begin lat = n; s = sp; end
            end
            if (!bz && bend < 0) bend = n;
            @(posedge clk); #1;
        end
    endtask

    typedef struct {
        bit          sel;
        logic [11:0] word;
        int          lat;
        int          nena;
        int          nrise;
        int          bend;
    } vec_t;

    vec_t        tbl[5];
    int          lat, nena, nrise, ncs, bend, nval, busy_fall, k, run, minrun;
    bit          seen_low;
    logic [11:0] s;
    int          t[3];
    logic [11:0] cs_words[3];
    logic [11:0] got[3];

    initial begin
        tbl[0] = '{1'b0, 12'hA5C, 133, 12, 16, 141};
        tbl[1] = '{1'b0, 12'h001, 133, 12, 16, 141};
        tbl[2] = '{1'b0, 12'hFFF, 133, 12, 16, 141};
        tbl[3] = '{1'b1, 12'hFFF,  51, 12, 12,  52};
        tbl[4] = '{1'b1, 12'h000,  51, 12, 12,  52};
        cs_words[0] = 12'h001; cs_words[1] = 12'h800; cs_words[2] = 12'hFFF;

        // Reset asserted at time zero, before any clock edge.
        rst1 = 1'b1; rst2 = 1'b1; start1 = 1'b1; start2 = 1'b1;
        #2;
        chk("rst_async_cs", cs1, 1); chk("rst_async_sclk", sclk1, 1);
        chk("rst_async_clr", clr1, 0); chk("rst_async_busy", busy1, 0);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            chk("rst_cs", cs1, 1); chk("rst_sclk", sclk1, 1); chk("rst_ena", ena1, 0);
            chk("rst_clr", clr1, 0); chk("rst_sample", samp1, 0);
            chk("rst_valid", valid1, 0); chk("rst_busy", busy1, 0);
            chk("rst2_cs", cs2, 1);
        end
        @(negedge clk);
        rst1 = 1'b0; rst2 = 1'b0; start1 = 1'b0; start2 = 1'b0;
        @(posedge clk); #1;

        // Table of single frames on both parameter sets.
        for (int i = 0; i < 5; i++) begin
            run_frame(tbl[i].sel, tbl[i].word, lat, s, nena, nrise, ncs, bend, nval);
            chk($sformatf("v%0d_latency", i), lat, tbl[i].lat);
            chk($sformatf("v%0d_sample", i), s, tbl[i].word);
            chk($sformatf("v%0d_ena_count", i), nena, tbl[i].nena);
            chk($sformatf("v%0d_sclk_rises", i), nrise, tbl[i].nrise);
            chk($sformatf("v%0d_cs_low_cycles", i), ncs, tbl[i].lat);
            chk($sformatf("v%0d_busy_fall", i), bend, tbl[i].bend);
            chk($sformatf("v%0d_valid_count", i), nval, 1);
        end

        // Second start during a frame is ignored.
        word1 = 12'h3C3; start1 = 1'b1;
        @(posedge clk); #1;
        start1 = 1'b0; nval = 0; busy_fall = -1;
        for (int n = 0; n < 300; n++) begin
            if (n == 49) start1 = 1'b1;
            if (n == 50) start1 = 1'b0;
            if (valid1) nval++;
            if (!busy1 && busy_fall < 0) busy_fall = n;
            @(posedge clk); #1;
        end
        chk("busyrej_valid_count", nval, 1);
        chk("busyrej_busy_fall", busy_fall, 141);
        chk("busyrej_sample", samp1, 12'h3C3);

        // start held high: back-to-back frames.
        word1 = cs_words[0]; start1 = 1'b1; k = 0; run = 0; minrun = 999; seen_low = 1'b0;
        for (int n = 0; n < 700; n++) begin
            @(posedge clk); #1;
            if (cs1) run++;
            else begin
                if (seen_low && run > 0 && run < minrun) minrun = run;
                run = 0; seen_low = 1'b1;
            end
            if (valid1 && k < 3) begin
                t[k] = n; got[k] = samp1; k++;
                if (k < 3) word1 = cs_words[k];
                else start1 = 1'b0;
            end
            if (k == 3 && !busy1) break;
        end
        start1 = 1'b0;
        chk("cont_frames", k, 3);
        if (k == 3) begin
            chk("cont_spacing_1", t[1] - t[0], 142);
            chk("cont_spacing_2", t[2] - t[1], 142);
            for (int i = 0; i < 3; i++) chk($sformatf("cont_word_%0d", i), got[i], cs_words[i]);
        end
        chk("cont_cs_gap_ge8", (minrun >= 8 && minrun < 999), 1);
        @(posedge clk); #1;

        // Abort mid-frame with an asynchronous reset just after E60.
        @(negedge clk); rst1 = 1'b1;
        @(negedge clk); rst1 = 1'b0;
        @(posedge clk); #1;
        word1 = 12'h123; start1 = 1'b1;
        @(posedge clk); #1;
        start1 = 1'b0;
        repeat (60) @(posedge clk);
        #1;
        chk("abort_pre_cs", cs1, 0);
        #2;
        rst1 = 1'b1;
        #1;
        chk("abort_cs", cs1, 1); chk("abort_sclk", sclk1, 1); chk("abort_valid", valid1, 0);
        chk("abort_busy", busy1, 0); chk("abort_clr", clr1, 0); chk("abort_sample", samp1, 0);
        @(negedge clk); rst1 = 1'b0;
        nval = 0;
        for (int n = 0; n < 200; n++) begin
            @(posedge clk); #1;
            if (valid1) nval++;
        end
        chk("abort_no_valid", nval, 0);
        chk("abort_sample_hold", samp1, 0);
        run_frame(1'b0, 12'h456, lat, s, nena, nrise, ncs, bend, nval);
        chk("after_abort_sample", s, 12'h456);
        chk("after_abort_latency", lat, 133);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nbad);
        $finish;
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
